// File: rtl/init_seq_fifo_if.sv
// Purpose: FIFO write/read handshake bundle for init_seq_fifo.
// Latency: none, wires only.
// Backpressure: if_full_n throttles the writer; if_empty_n qualifies if_dout.
// Ports: if_full_n/if_write_ce/if_write/if_din form the write side;
//        if_empty_n/if_read_ce/if_read/if_dout form the read side.
//        master = the producer/consumer endpoint, slave = the FIFO.
interface init_seq_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_full_n;
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_empty_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;

    modport master (
        input  if_full_n,
        output if_write_ce,
        output if_write,
        output if_din,
        input  if_empty_n,
        output if_read_ce,
        output if_read,
        input  if_dout
    );

    modport slave (
        output if_full_n,
        input  if_write_ce,
        input  if_write,
        input  if_din,
        output if_empty_n,
        input  if_read_ce,
        input  if_read,
        output if_dout
    );
endinterface

// File: rtl/init_seq_fifo.sv
// Purpose: FWFT FIFO that self-preloads base, base+stride, ... after reset or reinit.
// Latency: a write at edge t is visible at if_dout after edge t; preload takes 1+INIT_LENGTH cycles.
// Backpressure: if_full_n drops at count >= DEPTH-GRACE_PERIOD and is held low outside RELAY.
// Ports: clk, reset_n (async active-low); bus (slave modport of init_seq_fifo_if);
//        reinit (flush + re-preload request); init_done (high in RELAY only);
//        count (occupancy); err ({overflow, underflow} sticky).
// Optional: define INIT_SEQ_FIFO_ERR_CHECK_EN to build the sticky err detectors,
//           otherwise err is tied to 2'b00.
module init_seq_fifo #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 32,
    parameter int                    GRACE_PERIOD = 2,
    parameter int                    INIT_LENGTH  = 10,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE    = '0,
    parameter logic [DATA_WIDTH-1:0] INIT_STRIDE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1},
    localparam int                   AW           = $clog2(DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    init_seq_fifo_if.slave        bus,
    input  logic                  reinit,
    output logic                  init_done,
    output logic [AW-1:0]         count,
    output logic [1:0]            err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] DEPTH_C   = AW'(DEPTH);
    localparam logic [AW-1:0] FULL_THR  = AW'(DEPTH - GRACE_PERIOD);
    localparam logic [AW-1:0] INIT_LAST = AW'((INIT_LENGTH > 0) ? INIT_LENGTH - 1 : 0);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("init_seq_fifo: DEPTH must be >= 2");
    end
    if (INIT_LENGTH < 0 || INIT_LENGTH > DEPTH) begin : g_bad_init
        $error("init_seq_fifo: INIT_LENGTH must lie in 0..DEPTH");
    end
    if (GRACE_PERIOD < 0 || GRACE_PERIOD > DEPTH) begin : g_bad_grace
        $error("init_seq_fifo: GRACE_PERIOD must lie in 0..DEPTH");
    end

    typedef enum logic [1:0] {S_RESET, S_INIT, S_RELAY, S_FLUSH} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_seq;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_relay;
    logic                  w_init;
    logic                  w_wr_try;
    logic                  w_rd_try;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_dat;
    logic                  w_flush;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_relay  = (r_state == S_RELAY);
    assign w_init   = (r_state == S_INIT);
    assign w_wr_try = bus.if_write & bus.if_write_ce;
    assign w_rd_try = bus.if_read  & bus.if_read_ce;

    // Hard limit is DEPTH, not the almost-full threshold: the grace
    // window lets in-flight writes land after if_full_n drops.
    assign w_wr_acc = w_relay & w_wr_try & (r_count < DEPTH_C);
    assign w_rd_acc = w_relay & w_rd_try & (r_count != '0);

    // Preload and relay writes share the single write port; they are
    // mutually exclusive by state.
    assign w_push     = w_init | w_wr_acc;
    assign w_push_dat = w_init ? r_seq : bus.if_din;

    // The clear happens on the edge entering S_FLUSH, so the flush cycle
    // already shows an empty FIFO.
    assign w_flush = (w_state_nxt == S_FLUSH);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET: w_state_nxt = (INIT_LENGTH > 0) ? S_INIT : S_RELAY;
            S_INIT: begin
                // count equals the preload index k while in S_INIT.
                if (reinit)                    w_state_nxt = S_FLUSH;
                else if (r_count == INIT_LAST) w_state_nxt = S_RELAY;
            end
            S_RELAY: if (reinit) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = (INIT_LENGTH > 0) ? S_INIT : S_RELAY;
            default: w_state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_RESET;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_seq    <= INIT_BASE;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_seq    <= INIT_BASE;
            end else begin
                if (w_push)   r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                if (w_rd_acc) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                case ({w_push, w_rd_acc})
                    2'b10:   r_count <= r_count + AW'(1);
                    2'b01:   r_count <= r_count - AW'(1);
                    default: r_count <= r_count;
                endcase
                if (w_init) r_seq <= r_seq + INIT_STRIDE;
            end
        end
    end

    // Storage carries no reset; stale entries are never exposed because
    // if_dout is gated by if_empty_n.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_dat;
    end

    assign bus.if_full_n  = w_relay & (r_count < FULL_THR);
    assign bus.if_empty_n = w_relay & (r_count != '0);
    assign bus.if_dout    = bus.if_empty_n ? r_mem[r_rd_ptr] : '0;
    assign init_done      = w_relay;
    assign count          = r_count;

`ifdef INIT_SEQ_FIFO_ERR_CHECK_EN
    logic [1:0] r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 2'b00;
        end else begin
            if (w_relay & w_wr_try & (r_count == DEPTH_C)) r_err[1] <= 1'b1;
            if (w_relay & w_rd_try & (r_count == '0))      r_err[0] <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_init_seq_fifo.sv
// Purpose: scoreboard bench for init_seq_fifo (preload, relay, grace/overflow, reinit, async reset).
// Latency: expected data queued at stimulus time, popped by negedge monitors on each accepted read.
// Backpressure: monitors only pop when the DUT presents if_empty_n with an enabled read.
module tb_init_seq_fifo;

    localparam int DW = 16;
    localparam int AW = $clog2(8 + 1);

    logic          clk = 1'b0;
    logic          rst_a_n;
    logic          rst_b_n;
    logic          reinit_a;
    logic          reinit_b;
    logic          done_a;
    logic          done_b;
    logic [AW-1:0] count_a;
    logic [AW-1:0] count_b;
    logic [1:0]    err_a;
    logic [1:0]    err_b;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    init_seq_fifo_if #(.DATA_WIDTH(DW)) bus_a ();
    init_seq_fifo_if #(.DATA_WIDTH(DW)) bus_b ();

    // A: preloading instance; B: no preload, used for the grace/overflow case.
    init_seq_fifo #(
        .DATA_WIDTH(DW), .DEPTH(8), .GRACE_PERIOD(2), .INIT_LENGTH(4),
        .INIT_BASE(16'd16), .INIT_STRIDE(16'd3)
    ) u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .bus(bus_a.slave), .reinit(reinit_a),
        .init_done(done_a), .count(count_a), .err(err_a)
    );

    init_seq_fifo #(
        .DATA_WIDTH(DW), .DEPTH(8), .GRACE_PERIOD(2), .INIT_LENGTH(0),
        .INIT_BASE(16'd0), .INIT_STRIDE(16'd1)
    ) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .bus(bus_b.slave), .reinit(reinit_b),
        .init_done(done_b), .count(count_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_preload_a();
        qa.delete();
        qa.push_back(16'd16);
        qa.push_back(16'd19);
        qa.push_back(16'd22);
        qa.push_back(16'd25);
    endtask

    always @(negedge clk) begin
        if (bus_a.if_empty_n && bus_a.if_read && bus_a.if_read_ce) begin
            if (qa.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_a: popped %0d, scoreboard empty", bus_a.if_dout);
            end else begin
                chk("pop_a", 32'(bus_a.if_dout), 32'(qa.pop_front()));
            end
        end
        if (bus_b.if_empty_n && bus_b.if_read && bus_b.if_read_ce) begin
            if (qb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_b: popped %0d, scoreboard empty", bus_b.if_dout);
            end else begin
                chk("pop_b", 32'(bus_b.if_dout), 32'(qb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ovf_err;
        logic [1:0] all_err;
`ifdef INIT_SEQ_FIFO_ERR_CHECK_EN
        ovf_err = 2'b10;
        all_err = 2'b11;
`else
        ovf_err = 2'b00;
        all_err = 2'b00;
`endif
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        reinit_a = 1'b0;
        reinit_b = 1'b0;
        bus_a.if_write = 1'b0; bus_a.if_write_ce = 1'b1; bus_a.if_din = '0;
        bus_a.if_read  = 1'b1; bus_a.if_read_ce  = 1'b1;
        bus_b.if_write = 1'b0; bus_b.if_write_ce = 1'b1; bus_b.if_din = '0;
        bus_b.if_read  = 1'b0; bus_b.if_read_ce  = 1'b1;

        // Reset values.
        #2;
        chk("rst_count", 32'(count_a), 0);
        chk("rst_full_n", 32'(bus_a.if_full_n), 0);
        chk("rst_empty_n", 32'(bus_a.if_empty_n), 0);
        chk("rst_init_done", 32'(done_a), 0);
        chk("rst_dout", 32'(bus_a.if_dout), 0);
        chk("rst_err", 32'(err_a), 0);

        // Preload 16,19,22,25 with read held: RELAY after 5 edges, 4 consecutive pops.
        step(); step();
        rst_a_n = 1'b1;
        expect_preload_a();
        step(); step(); step(); step();
        chk("init_last_cycle_done", 32'(done_a), 0);
        chk("init_last_cycle_count", 32'(count_a), 3);
        chk("init_full_n_low", 32'(bus_a.if_full_n), 0);
        step();
        chk("relay_done", 32'(done_a), 1);
        chk("relay_count", 32'(count_a), 4);
        chk("relay_head", 32'(bus_a.if_dout), 16);
        step(); step(); step(); step();
        chk("drained_count", 32'(count_a), 0);
        chk("drained_empty_n", 32'(bus_a.if_empty_n), 0);

        // Write gated by write_ce, then count=3 and 10 simultaneous read+write cycles.
        bus_a.if_read = 1'b0;
        bus_a.if_write = 1'b1; bus_a.if_write_ce = 1'b0; bus_a.if_din = 16'd999;
        step();
        chk("write_ce_gate", 32'(count_a), 0);
        bus_a.if_write_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.if_din = DW'(100 + i);
            qa.push_back(DW'(100 + i));
            step();
        end
        chk("fill3_count", 32'(count_a), 3);
        bus_a.if_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_a.if_din = DW'(200 + i);
            qa.push_back(DW'(200 + i));
            step();
        end
        chk("rw_count_steady", 32'(count_a), 3);
        chk("rw_full_n", 32'(bus_a.if_full_n), 1);
        bus_a.if_write = 1'b0;
        step(); step(); step();
        chk("rw_drain_count", 32'(count_a), 0);
        bus_a.if_read = 1'b0;

        // Reinit in RELAY with count=5.
        bus_a.if_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_a.if_din = DW'(300 + i);
            step();
        end
        chk("pre_reinit_count", 32'(count_a), 5);
        bus_a.if_write = 1'b0;
        reinit_a = 1'b1;
        step();
        reinit_a = 1'b0;
        expect_preload_a();
        chk("flush_done", 32'(done_a), 0);
        chk("flush_count", 32'(count_a), 0);
        chk("flush_full_n", 32'(bus_a.if_full_n), 0);
        step(); step(); step(); step();
        chk("reinit_done_low", 32'(done_a), 0);
        step();
        chk("reinit_done_high", 32'(done_a), 1);
        chk("reinit_count", 32'(count_a), 4);
        bus_a.if_read = 1'b1;
        step(); step(); step(); step();
        chk("reinit_drain_count", 32'(count_a), 0);

        // Async reset at the 2nd S_INIT cycle, then a clean preload.
        rst_a_n = 1'b0;
        step();
        rst_a_n = 1'b1;
        qa.delete();
        step(); step();
        chk("mid_init_count", 32'(count_a), 1);
        rst_a_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count_a), 0);
        chk("async_rst_done", 32'(done_a), 0);
        chk("async_rst_empty_n", 32'(bus_a.if_empty_n), 0);
        chk("async_rst_err", 32'(err_a), 0);
        step();
        rst_a_n = 1'b1;
        expect_preload_a();
        step(); step(); step(); step();
        chk("rerun_done_low", 32'(done_a), 0);
        step();
        chk("rerun_done_high", 32'(done_a), 1);
        chk("rerun_head", 32'(bus_a.if_dout), 16);
        step(); step(); step(); step();
        chk("rerun_drain_count", 32'(count_a), 0);
        bus_a.if_read = 1'b0;

        // B: INIT_LENGTH=0, grace threshold and overflow drop.
        rst_b_n = 1'b1;
        step();
        chk("b_done", 32'(done_b), 1);
        chk("b_count", 32'(count_b), 0);
        chk("b_full_n", 32'(bus_b.if_full_n), 1);
        bus_b.if_write = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus_b.if_din = DW'(500 + k - 1);
            if (k <= 8) qb.push_back(DW'(500 + k - 1));
            step();
            chk("b_fill_count", 32'(count_b), (k > 8) ? 8 : k);
            chk("b_fill_full_n", 32'(bus_b.if_full_n), (k < 6) ? 1 : 0);
        end
        bus_b.if_write = 1'b0;
        chk("b_err_overflow", 32'(err_b), 32'(ovf_err));
        bus_b.if_read = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("b_drain_count", 32'(count_b), 0);
        step();
        chk("b_err_underflow", 32'(err_b), 32'(all_err));
        chk("b_empty_n", 32'(bus_b.if_empty_n), 0);
        bus_b.if_read = 1'b0;

        chk("qa_leftover", 32'(qa.size()), 0);
        chk("qb_leftover", 32'(qb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
